imem_fetch_unit: RTL and testbench
==================================

IMEM_FETCH_UNIT -- requirements
Module: imem_fetch_unit

Interface
REQ-001 Parameters SHALL be:
- DATA_W, default 32, instruction word width.
- ADDR_W, default 32, fetch address width.
- DEPTH, default 1024, number of words; power of two, at least 2.
- BYTE_ADDR, default 1; 1 = byte address (word index = addr >> 2), 0 = word address.
- NOP_WORD, default 32'h00000000, word driven when no valid instruction exists.
- PRELOADED, default 0; 1 = reset enters RUN directly.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- prog_valid  in  1  program-load word present.
- prog_addr  in  log2(DEPTH)  word index to write.
- prog_data  in  DATA_W  word to write.
- prog_last  in  1  final load word; qualified by prog_valid.
- req_valid  in  1  fetch request.
- req_ready  out  1  fetch request accepted this cycle.
- req_addr  in  ADDR_W  fetch address (the PC).
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer takes the response.
- rsp_instr  out  DATA_W  fetched word.
- rsp_fault  out  1  fetch was misaligned or out of range.
- loaded  out  1  high in RUN.
- fault_cnt  out  16  saturating count of faulting responses.

Function
REQ-003 The state machine SHALL have two states:
- LOAD: program loading.
- RUN: fetching.
REQ-004 In LOAD, prog_valid SHALL write prog_data to mem[prog_addr] on that edge.
REQ-005 In LOAD, prog_valid with prog_last SHALL write the word and enter RUN on the same edge.
REQ-006 In RUN, prog_* inputs SHALL be ignored; memory is read-only.
REQ-007 req_ready SHALL equal (state==RUN) and (rsp_valid==0 or rsp_ready==1), combinationally.
REQ-008 A request is accepted when req_valid and req_ready are both high; rsp_valid SHALL rise on the next edge (latency 1).
REQ-009 The response to an accepted request SHALL be:
- rsp_instr = mem[index].
- index = req_addr[log2(DEPTH)+1:2] when BYTE_ADDR=1, else req_addr[log2(DEPTH)-1:0].
REQ-010 Fault conditions SHALL be:
- Misaligned: BYTE_ADDR=1 and req_addr[1:0] != 0.
- Out of range: any req_addr bit above the index field is set.
REQ-011 A faulting request SHALL return rsp_fault=1 and rsp_instr=NOP_WORD; otherwise rsp_fault=0.
REQ-012 A response SHALL be held stable while rsp_valid=1 and rsp_ready=0.
REQ-013 When rsp_valid=1, rsp_ready=1 and a new request is accepted on the same edge, the register SHALL reload with the new result and rsp_valid SHALL stay 1 (full throughput).
REQ-014 When rsp_valid=1, rsp_ready=1 and no request is accepted, rsp_valid SHALL clear on that edge.
REQ-015 fault_cnt SHALL increment when a faulting request is accepted and SHALL saturate at 16'hFFFF.
REQ-016 loaded SHALL be 1 exactly when state==RUN.
REQ-017 Unwritten memory words read as undefined; contents are not initialised by this block.

Reset
REQ-018 On rst, asynchronously, outputs SHALL take these values:
- rsp_valid=0, rsp_instr=NOP_WORD, rsp_fault=0, fault_cnt=0.
- State = RUN if PRELOADED=1, else LOAD.
REQ-019 Memory contents SHALL NOT be altered by rst.
- Reset during LOAD keeps words already written and restarts in LOAD.
- Reset during RUN discards any in-flight response.
REQ-020 After rst deasserts, the first accepted request SHALL be no earlier than the first rising edge with rst low.

Verification
REQ-021 Load 4 words to indices 0..3 (0x11,0x22,0x33,0x44), prog_last on the 4th, then fetch addr 0x8 with BYTE_ADDR=1 -> rsp_valid next cycle, rsp_instr=0x33, rsp_fault=0, loaded=1.
REQ-022 Fetch addr 0x6 -> rsp_fault=1, rsp_instr=NOP_WORD, fault_cnt increments by 1; with DEPTH=1024, fetch addr 0x1000 -> rsp_fault=1.
REQ-023 Back-to-back fetches 0x0,0x4,0xC with rsp_ready=1 -> three consecutive responses 0x11,0x22,0x44 with no bubble.
REQ-024 Hold rsp_ready=0 for 3 cycles after a fetch -> req_ready=0 and the response is unchanged; raising rsp_ready with req_valid=1 -> next response delivered on the following edge.
REQ-025 Assert rst mid-load after 2 words -> state LOAD, rsp_valid=0; after 2 more words with prog_last, fetches of indices 0..3 return all four loaded words.
REQ-026 Force 65535 faulting fetches, then one more -> fault_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/imem_fetch_unit.sv
// Instruction memory with a load phase followed by a read-only fetch phase.
// One-deep response register gives 1-cycle fetch latency at full throughput.
module imem_fetch_unit #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 1024,
  parameter int                BYTE_ADDR = 1,
  parameter logic [DATA_W-1:0] NOP_WORD  = '0,
  parameter int                PRELOADED = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     prog_valid,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [DATA_W-1:0]        prog_data,
  input  logic                     prog_last,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_instr,
  output logic                     rsp_fault,
  output logic                     loaded,
  output logic [15:0]              fault_cnt
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LSB   = (BYTE_ADDR != 0) ? 2 : 0;

  typedef enum logic {LOAD, RUN} state_t;

  state_t              state_reg, state_next;
  logic                rsp_valid_reg;
  logic                rsp_fault_reg;
  logic                rsp_nop_reg;
  logic [15:0]         fault_cnt_reg;
  logic [DATA_W-1:0]   rd_data_reg;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [IDX_W-1:0]    rd_idx;
  logic                misaligned;
  logic                out_of_range;
  logic                req_fault;
  logic                accept;
  logic                mem_we;

  assign rd_idx = req_addr[LSB +: IDX_W];

  generate
    if (BYTE_ADDR != 0) begin : g_align
      assign misaligned = (req_addr[1:0] != 2'b00);
    end else begin : g_noalign
      assign misaligned = 1'b0;
    end

    if (ADDR_W > LSB + IDX_W) begin : g_range
      assign out_of_range = |req_addr[ADDR_W-1:LSB+IDX_W];
    end else begin : g_norange
      assign out_of_range = 1'b0;
    end
  endgenerate

  assign req_fault = misaligned | out_of_range;

  // rst gating keeps a PRELOADED part from accepting while still held in reset.
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    accept     = 1'b0;
    mem_we     = 1'b0;
    case (state_reg)
      LOAD: begin
        if (prog_valid && !rst) begin
          mem_we = 1'b1;
          if (prog_last)
            state_next = RUN;
        end
      end
      RUN: begin
        req_ready = !rst && (!rsp_valid_reg || rsp_ready);
        accept    = req_valid && req_ready;
      end
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= (PRELOADED != 0) ? RUN : LOAD;
      rsp_valid_reg <= 1'b0;
      rsp_fault_reg <= 1'b0;
      rsp_nop_reg   <= 1'b1;
      fault_cnt_reg <= 16'h0000;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        rsp_valid_reg <= 1'b1;
        rsp_fault_reg <= req_fault;
        rsp_nop_reg   <= req_fault;
        if (req_fault && (fault_cnt_reg != 16'hFFFF))
          fault_cnt_reg <= fault_cnt_reg + 16'd1;
      end else if (rsp_ready) begin
        rsp_valid_reg <= 1'b0;
      end
    end
  end

  // Memory and its read register carry no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[prog_addr] <= prog_data;
    if (accept)
      rd_data_reg <= mem[rd_idx];
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_fault = rsp_fault_reg;
  assign rsp_instr = rsp_nop_reg ? NOP_WORD : rd_data_reg;
  assign loaded    = (state_reg == RUN);
  assign fault_cnt = fault_cnt_reg;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Scoreboarded bench for imem_fetch_unit: directed load/fetch scenarios plus
// randomized fetch traffic against an address-arithmetic reference model.
module tb_imem_fetch_unit;

  localparam int                DATA_W = 32;
  localparam int                ADDR_W = 32;
  localparam int                DEPTH  = 1024;
  localparam logic [DATA_W-1:0] NOP    = 32'h00000013;

  logic              clk;
  logic              rst;
  logic              prog_valid;
  logic [9:0]        prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              prog_last;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_instr;
  logic              rsp_fault;
  logic              loaded;
  logic [15:0]       fault_cnt;

  imem_fetch_unit #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .BYTE_ADDR(1), .NOP_WORD(NOP), .PRELOADED(0)
  ) dut (
    .clk(clk), .rst(rst),
    .prog_valid(prog_valid), .prog_addr(prog_addr), .prog_data(prog_data), .prog_last(prog_last),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr), .rsp_fault(rsp_fault),
    .loaded(loaded), .fault_cnt(fault_cnt)
  );

  typedef struct {
    logic [DATA_W-1:0] instr;
    logic              fault;
  } exp_t;

  exp_t              sb[$];
  exp_t              mon_e;
  logic [DATA_W-1:0] model_mem [int];
  int                total = 0;
  int                bad = 0;
  int                model_fc = 0;
  bit                model_run = 0;
  bit                rand_rdy = 0;
  bit                quiet = 0;
  int                last_wait = 0;
  int                rsp_n = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a response is consumed whenever valid and ready meet at an edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_unexpected: got instr=%0h fault=%0b with no request pending", rsp_instr, rsp_fault);
        end else begin
          mon_e = sb.pop_front();
          rsp_n++;
          if (!quiet)
            $display("rsp %0d: instr=%08h fault=%0b (want %08h/%0b)", rsp_n, rsp_instr, rsp_fault, mon_e.instr, mon_e.fault);
          chk("rsp_instr", rsp_instr, mon_e.instr);
          chk("rsp_fault", rsp_fault, mon_e.fault);
        end
      end
    end
  end

  // Random consumer back-pressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy)
        rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the write edge.
  task automatic load(input int idx, input logic [DATA_W-1:0] data, input bit last);
    prog_valid = 1'b1;
    prog_addr  = idx[9:0];
    prog_data  = data;
    prog_last  = last;
    @(posedge clk);
    if (!model_run) begin
      model_mem[idx] = data;
      if (last) model_run = 1;
    end
    #1;
    prog_valid = 1'b0;
    prog_last  = 1'b0;
  endtask

  // Called at posedge+1; leaves req_valid high; returns at posedge+1 after acceptance.
  task automatic issue(input logic [ADDR_W-1:0] a);
    int   n;
    bit   acc;
    bit   f;
    exp_t e;
    n   = 0;
    acc = 0;
    req_addr  = a;
    req_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      #1;
      if (req_ready) acc = 1;
      else n++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: addr=%0h not accepted, required acceptance within 200 cycles", a);
      req_valid = 1'b0;
      last_wait = n;
      return;
    end
    f = (a % 4 != 0) || (longint'(a) >= longint'(DEPTH) * 4);
    e.fault = f;
    e.instr = f ? NOP : model_mem[int'(a / 4)];
    sb.push_back(e);
    if (f && model_fc < 65535) model_fc++;
    last_wait = n;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    model_run = 0;
    model_fc  = 0;
    #2;
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_instr", rsp_instr, NOP);
    chk("rst_rsp_fault", rsp_fault, 1'b0);
    chk("rst_fault_cnt", fault_cnt, 16'h0000);
    chk("rst_loaded", loaded, 1'b0);
    chk("rst_req_ready", req_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  int          r;
  int          idx;
  logic [31:0] a;

  initial begin
    rst = 1'b0;
    prog_valid = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    prog_last = 1'b0;
    req_valid = 1'b0;
    req_addr = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Reset part-way through loading; earlier words must survive.
    load(0, 32'h11, 0);
    load(1, 32'h22, 0);
    do_reset();
    load(2, 32'h33, 0);
    load(3, 32'h44, 1);
    chk("loaded_after_last", loaded, 1'b1);

    issue(32'h8);
    req_valid = 1'b0;
    @(negedge clk);
    chk("latency_rsp_valid", rsp_valid, 1'b1);
    chk("fetch8_instr", rsp_instr, 32'h33);
    @(posedge clk); #1;

    issue(32'h6);
    req_valid = 1'b0;
    @(negedge clk);
    chk("fault_inc", fault_cnt, 16'd1);
    chk("misaligned_fault", rsp_fault, 1'b1);
    @(posedge clk); #1;
    issue(32'h1000);
    req_valid = 1'b0;
    @(negedge clk);
    chk("range_fault", rsp_fault, 1'b1);
    @(posedge clk); #1;

    // Back-to-back with the consumer always ready: no bubbles.
    issue(32'h0);
    chk("b2b_wait0", last_wait, 0);
    issue(32'h4);
    chk("b2b_wait1", last_wait, 0);
    issue(32'hC);
    chk("b2b_wait2", last_wait, 0);
    req_valid = 1'b0;
    @(posedge clk); #1;

    // Stall the consumer for three cycles with a request pending.
    rsp_ready = 1'b0;
    issue(32'h4);
    req_addr = 32'hC;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("hold_req_ready", req_ready, 1'b0);
      chk("hold_rsp_valid", rsp_valid, 1'b1);
      chk("hold_rsp_instr", rsp_instr, 32'h22);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    issue(32'hC);
    chk("release_wait", last_wait, 0);
    req_valid = 1'b0;
    @(negedge clk);
    chk("release_rsp_valid", rsp_valid, 1'b1);
    chk("release_rsp_instr", rsp_instr, 32'h44);
    @(posedge clk); #1;

    // Reset in RUN drops an in-flight response and returns to LOAD.
    rsp_ready = 1'b0;
    issue(32'h0);
    req_valid = 1'b0;
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 4; i < 64; i++)
      load(i, $urandom, (i == 63));
    chk("reload_loaded", loaded, 1'b1);

    // Randomized traffic with random back-pressure.
    rand_rdy = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        @(posedge clk); #1;
      end
      r   = $urandom_range(0, 99);
      idx = $urandom_range(0, 63);
      if (r < 70)      a = idx * 4;
      else if (r < 85) a = idx * 4 + $urandom_range(1, 3);
      else             a = idx * 4 + 4096 * $urandom_range(1, 1000);
      issue(a);
    end
    req_valid = 1'b0;
    rand_rdy = 0;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("drain_empty", sb.size(), 0);
    chk("rand_fault_cnt", fault_cnt, model_fc[15:0]);

    // Drive the fault counter to saturation and one beyond.
    quiet = 1;
    while (model_fc < 65535)
      issue(32'h6);
    req_valid = 1'b0;
    @(negedge clk);
    chk("sat_reach", fault_cnt, 16'hFFFF);
    @(posedge clk); #1;
    issue(32'h6);
    req_valid = 1'b0;
    @(negedge clk);
    chk("sat_hold", fault_cnt, 16'hFFFF);
    quiet = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("final_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
